// File: rtl/pulse_report_uart.sv
// Snapshots TIME_HIGH/TIME_LOW/PERIOD on an accepted PULSE and streams them as an 8N1 UART frame.
// Optional trailing XOR checksum byte when REPORT_CHECKSUM_EN is defined.
//
// state   | meaning
// S_IDLE  | TX high, waiting for PULSE with ENABLE
// S_START | start bit (0) of the current byte
// S_DATA  | 8 data bits, LSB first
// S_STOP  | stop bit (1); then next byte or back to idle
module pulse_report_uart #(
    parameter int         COUNTER_BITS = 16,
    parameter int         CLOCK_FREQ   = 50_000_000,
    parameter int         BAUD_RATE    = 115200,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic [COUNTER_BITS-1:0] TIME_HIGH,
    input  logic [COUNTER_BITS-1:0] TIME_LOW,
    input  logic [COUNTER_BITS-1:0] PERIOD,
    input  logic                    PULSE,
    input  logic                    ENABLE,
    output logic                    TX,
    output logic                    BUSY,
    output logic [7:0]              DROP_CNT
);

    localparam int DIV = CLOCK_FREQ / BAUD_RATE;
    localparam int NB  = COUNTER_BITS / 8;
`ifdef REPORT_CHECKSUM_EN
    localparam int NF  = 2 + 3 * NB;
`else
    localparam int NF  = 1 + 3 * NB;
`endif
    localparam int FW     = NF * 8;
    localparam int BAUD_W = (DIV < 2) ? 1 : $clog2(DIV);
    localparam int BYTE_W = $clog2(NF);

    generate
        if (DIV < 2) begin : g_div_chk
            $error("pulse_report_uart: CLOCK_FREQ/BAUD_RATE must be at least 2");
        end
        if ((COUNTER_BITS % 8) != 0 || COUNTER_BITS < 8 || COUNTER_BITS > 32) begin : g_cb_chk
            $error("pulse_report_uart: COUNTER_BITS must be a multiple of 8 in 8..32");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t              r_state;
    logic [BAUD_W-1:0]   r_baud;
    logic [2:0]          r_bit;
    logic [BYTE_W-1:0]   r_byte;
    logic [FW-1:0]       r_frame;
    logic                r_tx;
    logic [7:0]          r_drop;

    state_t              w_state_nxt;
    logic [BAUD_W-1:0]   w_baud_nxt;
    logic [2:0]          w_bit_nxt;
    logic [BYTE_W-1:0]   w_byte_nxt;
    logic [FW-1:0]       w_frame_nxt;
    logic                w_tx_nxt;
    logic                w_accept;
    logic [7:0]          w_cur_byte;
    logic [2:0]          w_bit_inc;
    logic [FW-1:0]       w_load;

`ifdef REPORT_CHECKSUM_EN
    logic [7:0]          w_chk;

    always_comb begin
        w_chk = 8'h00;
        for (int i = 0; i < NB; i++) begin
            w_chk = w_chk ^ TIME_HIGH[i*8 +: 8] ^ TIME_LOW[i*8 +: 8] ^ PERIOD[i*8 +: 8];
        end
    end

    assign w_load = {SYNC_BYTE, TIME_HIGH, TIME_LOW, PERIOD, w_chk};
`else
    assign w_load = {SYNC_BYTE, TIME_HIGH, TIME_LOW, PERIOD};
`endif

    assign w_accept   = PULSE && ENABLE && (r_state == S_IDLE);
    assign w_cur_byte = r_frame[FW-1 -: 8];
    assign w_bit_inc  = r_bit + 3'd1;

    // Next TX level is computed here so TX itself is a plain register.
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud;
        w_bit_nxt   = r_bit;
        w_byte_nxt  = r_byte;
        w_frame_nxt = r_frame;
        w_tx_nxt    = r_tx;
        case (r_state)
            S_IDLE: begin
                w_tx_nxt = 1'b1;
                if (w_accept) begin
                    w_state_nxt = S_START;
                    w_baud_nxt  = BAUD_W'(DIV - 1);
                    w_byte_nxt  = BYTE_W'(NF - 1);
                    w_frame_nxt = w_load;
                    w_tx_nxt    = 1'b0;
                end
            end
            S_START: begin
                if (r_baud == '0) begin
                    w_state_nxt = S_DATA;
                    w_baud_nxt  = BAUD_W'(DIV - 1);
                    w_bit_nxt   = 3'd0;
                    w_tx_nxt    = w_cur_byte[0];
                end else begin
                    w_baud_nxt  = r_baud - 1'b1;
                end
            end
            S_DATA: begin
                if (r_baud == '0) begin
                    w_baud_nxt = BAUD_W'(DIV - 1);
                    if (r_bit == 3'd7) begin
                        w_state_nxt = S_STOP;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_bit_nxt   = w_bit_inc;
                        w_tx_nxt    = w_cur_byte[w_bit_inc];
                    end
                end else begin
                    w_baud_nxt = r_baud - 1'b1;
                end
            end
            S_STOP: begin
                if (r_baud == '0) begin
                    if (r_byte == '0) begin
                        w_state_nxt = S_IDLE;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_state_nxt = S_START;
                        w_baud_nxt  = BAUD_W'(DIV - 1);
                        w_byte_nxt  = r_byte - 1'b1;
                        w_frame_nxt = {r_frame[FW-9:0], 8'h00};
                        w_tx_nxt    = 1'b0;
                    end
                end else begin
                    w_baud_nxt = r_baud - 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_byte  <= '0;
            r_frame <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_byte  <= w_byte_nxt;
            r_frame <= w_frame_nxt;
            r_tx    <= w_tx_nxt;
        end
    end

    // Any strobe seen while a frame is in flight is lost, including the last stop-bit cycle.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_drop <= 8'h00;
        end else if (PULSE && (r_state != S_IDLE) && (r_drop != 8'hFF)) begin
            r_drop <= r_drop + 8'h01;
        end
    end

    assign TX       = r_tx;
    assign BUSY     = (r_state != S_IDLE);
    assign DROP_CNT = r_drop;

endmodule

// File: tb/tb_pulse_report_uart.sv
// Randomized self-checking bench for pulse_report_uart: decodes TX bit-by-bit at mid-bit
// sample points and compares against frames built from the measurement words.
module tb_pulse_report_uart;

    localparam int DIV = 10;
`ifdef REPORT_CHECKSUM_EN
    localparam int NF = 8;
`else
    localparam int NF = 7;
`endif
    localparam int FLEN = NF * 10 * DIV;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [15:0] TIME_HIGH;
    logic [15:0] TIME_LOW;
    logic [15:0] PERIOD;
    logic        PULSE;
    logic        ENABLE;
    logic        TX;
    logic        BUSY;
    logic [7:0]  DROP_CNT;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_drop = 0;
    logic smp[$];

    pulse_report_uart #(
        .COUNTER_BITS(16),
        .CLOCK_FREQ  (1_000_000),
        .BAUD_RATE   (100_000),
        .SYNC_BYTE   (8'hA5)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .TIME_HIGH(TIME_HIGH),
        .TIME_LOW (TIME_LOW),
        .PERIOD   (PERIOD),
        .PULSE    (PULSE),
        .ENABLE   (ENABLE),
        .TX       (TX),
        .BUSY     (BUSY),
        .DROP_CNT (DROP_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic smp_at(input int i);
        if (i < smp.size()) return smp[i];
        return 1'bx;
    endfunction

    function automatic int sat_add(input int a, input int n);
        return (a + n > 255) ? 255 : a + n;
    endfunction

    task automatic scramble();
        TIME_HIGH = 16'($urandom);
        TIME_LOW  = 16'($urandom);
        PERIOD    = 16'($urandom);
    endtask

    task automatic start_frame(input logic [15:0] th, input logic [15:0] tl, input logic [15:0] p);
        @(posedge CLK); #1;
        TIME_HIGH = th; TIME_LOW = tl; PERIOD = p;
        ENABLE = 1'b1; PULSE = 1'b1;
        @(posedge CLK); #1;
        PULSE = 1'b0;
        scramble();
        check("tx_fall_latency", 32'(TX), 32'd0);
        check("busy_rise_latency", 32'(BUSY), 32'd1);
    endtask

    task automatic capture(output int len);
        bit done;
        len = 0;
        done = 1'b0;
        smp.delete();
        while (!done) begin
            @(negedge CLK);
            if (!BUSY) begin
                done = 1'b1;
            end else begin
                smp.push_back(TX);
                len++;
                if (len > 4 * FLEN) begin
                    check("capture_timeout", 32'(len), 32'(FLEN));
                    done = 1'b1;
                end
            end
        end
    endtask

    task automatic check_frame(input string tag, input logic [15:0] th, input logic [15:0] tl,
                               input logic [15:0] p, input int len);
        logic [7:0] e[$];
        logic [7:0] cs;
        e = {8'hA5, th[15:8], th[7:0], tl[15:8], tl[7:0], p[15:8], p[7:0]};
        cs = th[15:8] ^ th[7:0] ^ tl[15:8] ^ tl[7:0] ^ p[15:8] ^ p[7:0];
`ifdef REPORT_CHECKSUM_EN
        e.push_back(cs);
`endif
        check($sformatf("%s_busy_len", tag), 32'(len), 32'(FLEN));
        for (int b = 0; b < NF; b++) begin
            int base;
            logic [7:0] d;
            logic st, sp;
            base = b * 10 * DIV + DIV / 2;
            st = smp_at(base);
            for (int j = 0; j < 8; j++) d[j] = smp_at(base + (j + 1) * DIV);
            sp = smp_at(base + 9 * DIV);
            check($sformatf("%s_byte%0d", tag, b), {22'd0, st, sp, d}, {22'd0, 1'b0, 1'b1, e[b]});
        end
    endtask

    initial begin
        int len, len2;
        logic [15:0] a0, a1, a2, y0, y1, y2;
        bit tx_hi, busy_lo;

        RST_N = 1'b0; PULSE = 1'b0; ENABLE = 1'b0;
        TIME_HIGH = '0; TIME_LOW = '0; PERIOD = '0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_tx", 32'(TX), 32'd1);
        check("reset_busy", 32'(BUSY), 32'd0);
        check("reset_drop", 32'(DROP_CNT), 32'd0);
        RST_N = 1'b1;

        start_frame(16'h1234, 16'h0056, 16'h128A);
        capture(len);
        check_frame("directed", 16'h1234, 16'h0056, 16'h128A, len);
        check("directed_drop", 32'(DROP_CNT), 32'(exp_drop));

        for (int k = 0; k < 3; k++) begin
            a0 = 16'($urandom); a1 = 16'($urandom); a2 = 16'($urandom);
            repeat ($urandom_range(0, 5)) @(posedge CLK);
            start_frame(a0, a1, a2);
            capture(len);
            check_frame($sformatf("rand%0d", k), a0, a1, a2, len);
        end

        // Three strobes with fresh data mid-frame must not disturb the snapshot.
        a0 = 16'($urandom); a1 = 16'($urandom); a2 = 16'($urandom);
        start_frame(a0, a1, a2);
        fork
            capture(len);
            begin
                for (int k = 0; k < 3; k++) begin
                    repeat ($urandom_range(20, 150)) @(posedge CLK);
                    #1; scramble(); PULSE = 1'b1;
                    @(posedge CLK); #1; PULSE = 1'b0;
                end
            end
        join
        exp_drop = sat_add(exp_drop, 3);
        check_frame("drop3", a0, a1, a2, len);
        check("drop3_cnt", 32'(DROP_CNT), 32'(exp_drop));

        a0 = 16'($urandom); a1 = 16'($urandom); a2 = 16'($urandom);
        start_frame(a0, a1, a2);
        fork
            capture(len);
            begin
                repeat (100) @(posedge CLK);
                #1; ENABLE = 1'b0;
            end
        join
        check_frame("enable_drop", a0, a1, a2, len);

        tx_hi = 1'b1; busy_lo = 1'b1;
        @(posedge CLK); #1; PULSE = 1'b1;
        repeat (5) begin
            @(posedge CLK); #1; scramble();
            tx_hi &= (TX === 1'b1); busy_lo &= (BUSY === 1'b0);
        end
        PULSE = 1'b0;
        repeat (20) begin
            @(posedge CLK); #1;
            tx_hi &= (TX === 1'b1); busy_lo &= (BUSY === 1'b0);
        end
        check("disabled_tx_idle", 32'(tx_hi), 32'd1);
        check("disabled_busy_low", 32'(busy_lo), 32'd1);
        check("disabled_drop", 32'(DROP_CNT), 32'(exp_drop));

        a0 = 16'($urandom); a1 = 16'($urandom); a2 = 16'($urandom);
        start_frame(a0, a1, a2);
        fork
            capture(len);
            begin
                repeat (10) @(posedge CLK);
                #1; PULSE = 1'b1;
                repeat (300) @(posedge CLK);
                #1; PULSE = 1'b0;
            end
        join
        exp_drop = sat_add(exp_drop, 300);
        check_frame("sat", a0, a1, a2, len);
        check("sat_drop", 32'(DROP_CNT), 32'(exp_drop));

        a0 = 16'($urandom); a1 = 16'($urandom); a2 = 16'($urandom);
        start_frame(a0, a1, a2);
        fork
            capture(len);
            begin
                repeat (249) @(posedge CLK);
                #1; RST_N = 1'b0;
                @(posedge CLK); #1; RST_N = 1'b1;
                check("midrst_tx", 32'(TX), 32'd1);
                check("midrst_busy", 32'(BUSY), 32'd0);
                check("midrst_drop", 32'(DROP_CNT), 32'd0);
            end
        join
        exp_drop = 0;
        check("midrst_aborted_len", 32'(len < FLEN), 32'd1);
        a0 = 16'($urandom); a1 = 16'($urandom); a2 = 16'($urandom);
        start_frame(a0, a1, a2);
        capture(len);
        check_frame("after_rst", a0, a1, a2, len);

        // Strobe held across the last stop-bit cycle (dropped) and the first idle cycle (accepted).
        a0 = 16'($urandom); a1 = 16'($urandom); a2 = 16'($urandom);
        y0 = 16'($urandom); y1 = 16'($urandom); y2 = 16'($urandom);
        start_frame(a0, a1, a2);
        fork
            capture(len);
            begin
                repeat (FLEN - 1) @(posedge CLK);
                #1; scramble(); PULSE = 1'b1;
                @(posedge CLK); #1;
                TIME_HIGH = y0; TIME_LOW = y1; PERIOD = y2;
                @(posedge CLK); #1; PULSE = 1'b0; scramble();
            end
        join
        exp_drop = sat_add(exp_drop, 1);
        check_frame("edge_a", a0, a1, a2, len);
        capture(len2);
        check_frame("edge_b", y0, y1, y2, len2);
        check("edge_drop", 32'(DROP_CNT), 32'(exp_drop));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pulse_report_uart.md
Name: pulse_report_uart

Overview:
Downstream consumer of frequency_counter. Snapshots TIME_HIGH/TIME_LOW/PERIOD on each PULSE strobe and streams them as a framed 8N1 UART packet on one pin. Gives the pulse-width counter a full-resolution serial readout alongside the 8-bit parallel mux output. Instantiated beside the mux in the top level; TX is routed to a spare uio pin.

Parameters:
COUNTER_BITS, 16, width of each measurement word; multiple of 8, range 8..32.
CLOCK_FREQ, 50_000_000, CLK frequency in Hz.
BAUD_RATE, 115200, UART bit rate.
SYNC_BYTE, 8'hA5, first byte of every frame.

Ports:
CLK  input  1  system clock; all logic on the rising edge.
RST_N  input  1  synchronous reset, active-low, sampled on the CLK rising edge.
TIME_HIGH  input  COUNTER_BITS  high-time measurement from frequency_counter.
TIME_LOW  input  COUNTER_BITS  low-time measurement.
PERIOD  input  COUNTER_BITS  period measurement.
PULSE  input  1  one-cycle strobe; the three words are valid in that cycle.
ENABLE  input  1  high = accept new frames.
TX  output  1  UART serial out; idles high.
BUSY  output  1  high while a frame is in flight.
DROP_CNT  output  8  count of PULSE strobes lost while BUSY; saturates at 255.

Behaviour:
- One clock, CLK. Reset is synchronous, active-low, on RST_N.
- Reset values: TX=1, BUSY=0, DROP_CNT=0, FSM=IDLE, all counters 0. Reset mid-frame aborts the frame. TX is 1 from the first cycle after the reset edge.
- DIV = CLOCK_FREQ/BAUD_RATE, truncated. Elaboration error if DIV<2. A bit counter holds each bit for exactly DIV cycles.
- NB = COUNTER_BITS/8. Frame byte order:
  - SYNC_BYTE
  - TIME_HIGH, MSB byte first
  - TIME_LOW, MSB byte first
  - PERIOD, MSB byte first
  - Frame length NF = 1+3*NB bytes; 7 at default.
- Each byte: start bit 0, 8 data bits LSB first, stop bit 1. No idle gap between bytes.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on an edge where PULSE=1, ENABLE=1, BUSY=0. The three inputs are captured into a snapshot register on that edge.
  - TX=0 and BUSY=1 from the cycle after the accept edge (latency 1).
  - START -> DATA after DIV cycles.
  - DATA -> STOP after 8*DIV cycles.
  - STOP -> START (next byte) after DIV cycles, or -> IDLE after the last byte.
  - BUSY falls in the cycle after the final stop bit's last cycle.
- Total frame time: NF*10*DIV cycles from TX falling to BUSY falling.
- PULSE while BUSY=1: frame unaffected, snapshot unchanged, DROP_CNT += 1 (saturating). This includes a PULSE in the final stop-bit cycle.
- PULSE while ENABLE=0 and BUSY=0: ignored, not counted.
- ENABLE falling mid-frame: the current frame completes normally.
- Input changes outside an accept edge have no effect on TX.
- TX is driven from a register, so it is glitch-free.

Optional Feature:
- Macro: REPORT_CHECKSUM_EN.
- When defined: one byte is appended after PERIOD, the XOR of all payload bytes excluding SYNC_BYTE. NF = 2+3*NB (8 at default). Frame time scales accordingly.
- When undefined: no checksum byte; NF = 1+3*NB. No checksum logic is synthesized.

Test Plan:
- Sim params CLOCK_FREQ=1_000_000, BAUD_RATE=100_000 (DIV=10). Reset, then TH=16'h1234, TL=16'h0056, P=16'h128A with PULSE for 1 cycle, ENABLE=1 -> TX falls 1 cycle later. Decoded bytes: A5 12 34 00 56 12 8A. BUSY high for exactly 700 cycles. DROP_CNT=0.
- Same stimulus with REPORT_CHECKSUM_EN defined -> bytes A5 12 34 00 56 12 8A E8. BUSY high for 800 cycles.
- During a frame, pulse PULSE 3 times with different data -> transmitted bytes are unchanged from the original snapshot; DROP_CNT=3 at the end. 300 strobes while BUSY -> DROP_CNT=255.
- ENABLE=0 with PULSE -> TX stays 1, BUSY stays 0, DROP_CNT stays 0. ENABLE dropped at cycle 100 of a frame -> frame completes all bytes.
- RST_N=0 for one edge at cycle 250 of a frame -> next cycle TX=1, BUSY=0, DROP_CNT=0. A following PULSE starts a fresh, correct frame.
- PULSE exactly in the cycle BUSY first reads 0 -> accepted, new frame starts. PULSE in the preceding (last stop-bit) cycle -> dropped, DROP_CNT increments.
